hydra_router: RTL and testbench

Parametrised N-port Hydra packet router for the LArPix chip-to-chip network: the next-generation replacement for the fixed four-UART routing inside the external interface. It sits between NUM_PORTS UART instances, the shared event FIFO, and the comms controller. It arbitrates round-robin over all enabled RX ports plus the local FIFO. It checks odd parity and routes each packet to local, upstream or downstream ports by packet type and chip ID. It embeds FIFO status in local config replies, then keeps saturating forwarded/dropped statistics.

---
 rtl/hydra_router.sv | 262 ++++++++++++++++++++++++++
 tb/tb_hydra_router.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hydra_router.sv
// -----------------------------------------------------------------------------
// hydra_router
//
// N-port Hydra packet router for the LArPix chip-to-chip network. Sits between
// NUM_PORTS UART instances, the shared event FIFO and the comms controller.
//
// One packet is in flight at a time:
//   1. A round-robin arbiter picks one of the enabled RX ports or the local
//      FIFO, pops it and latches the packet.
//   2. RX packets are parity-checked (odd parity, bit WIDTH-1) and routed by
//      type and chip ID. Local packets always go upstream.
//   3. The packet is loaded into every target UART once they are all idle,
//      and/or handed to the comms controller.
//   4. Saturating statistics count forwarded and dropped packets.
//
// Config replies from this chip that come from the local FIFO get the FIFO
// status flags written into bits [WIDTH-3:WIDTH-4], and their parity is
// recomputed.
//
// Ports
//   clk, reset_n_clk          master clock, async active-low reset
//   chip_id                   this chip's ID
//   enable_posi               per-port RX enable
//   enable_piso_upstream      TX mask for upstream traffic
//   enable_piso_downstream    TX mask for downstream traffic
//   rx_data/rx_valid/rx_ack   per-port RX packet, valid flag, one-cycle pop
//   local_data/valid/ack      head of the shared FIFO, not-empty flag, pop
//   fifo_full, fifo_half      FIFO status flags
//   to_local_data/valid/ready packet addressed to this chip (valid/ready)
//   tx_data, ld_tx, tx_busy   per-port TX packet, load strobe, UART busy
//   pkt_forwarded/dropped     saturating statistics counters
// -----------------------------------------------------------------------------
module hydra_router #(
  parameter int         WIDTH     = 64,
  parameter int         NUM_PORTS = 4,
  parameter logic [7:0] GLOBAL_ID = 8'hFF,
  parameter int         CNT_BITS  = 16
) (
  input  logic                       clk,
  input  logic                       reset_n_clk,
  input  logic [7:0]                 chip_id,
  input  logic [NUM_PORTS-1:0]       enable_posi,
  input  logic [NUM_PORTS-1:0]       enable_piso_upstream,
  input  logic [NUM_PORTS-1:0]       enable_piso_downstream,
  input  logic [NUM_PORTS*WIDTH-1:0] rx_data,
  input  logic [NUM_PORTS-1:0]       rx_valid,
  output logic [NUM_PORTS-1:0]       rx_ack,
  input  logic [WIDTH-1:0]           local_data,
  input  logic                       local_valid,
  output logic                       local_ack,
  input  logic                       fifo_full,
  input  logic                       fifo_half,
  output logic [WIDTH-1:0]           to_local_data,
  output logic                       to_local_valid,
  input  logic                       to_local_ready,
  output logic [NUM_PORTS*WIDTH-1:0] tx_data,
  output logic [NUM_PORTS-1:0]       ld_tx,
  input  logic [NUM_PORTS-1:0]       tx_busy,
  output logic [CNT_BITS-1:0]        pkt_forwarded,
  output logic [CNT_BITS-1:0]        pkt_dropped
);

  // Slots 0..NUM_PORTS-1 are RX ports; slot NUM_PORTS is the local FIFO.
  localparam int SLOTS  = NUM_PORTS + 1;
  localparam int SLOT_W = $clog2(SLOTS);

  typedef enum logic [2:0] {
    IDLE, GRANT, CLASSIFY, WAIT_TX, LOAD, GUARD, DELIVER
  } state_t;

  state_t               state;
  logic [SLOT_W-1:0]    ptr;
  logic [WIDTH-1:0]     pkt_reg;
  logic                 src_local;
  logic [NUM_PORTS-1:0] src_mask;
  logic [NUM_PORTS-1:0] target;
  logic                 local_pend;
  logic                 fifo_full_d;
  logic                 fifo_half_d;

  // ---------------------------------------------------------------------------
  // Round-robin arbiter: first active slot at or after ptr, wrapping.
  // ---------------------------------------------------------------------------
  logic [SLOTS-1:0]  req;
  logic              grant_found;
  logic [SLOT_W-1:0] grant_idx;
  logic              grant_local;

  assign req         = {local_valid, rx_valid & enable_posi};
  assign grant_local = (grant_idx == SLOT_W'(NUM_PORTS));

  // NOTE: every variable assigned in a combinational block gets a default at
  // the top, so no path can leave it unassigned and infer a latch.
  always_comb begin
    int slot;
    grant_found = 1'b0;
    grant_idx   = '0;
    slot        = 0;
    for (int k = 0; k < SLOTS; k++) begin
      slot = int'(ptr) + k;
      if (slot >= SLOTS) slot = slot - SLOTS;
      if (!grant_found && req[slot]) begin
        grant_found = 1'b1;
        grant_idx   = SLOT_W'(slot);
      end
    end
  end

  // Packet selected by the arbiter. A local config reply for this chip gets
  // the FIFO status (registered last cycle) and a recomputed parity bit.
  logic [WIDTH-1:0]     grant_pkt;
  logic [NUM_PORTS-1:0] grant_src;

  always_comb begin
    grant_pkt = local_data;
    grant_src = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant_idx == SLOT_W'(i)) begin
        grant_pkt    = rx_data[i*WIDTH +: WIDTH];
        grant_src[i] = 1'b1;
      end
    end
    if (grant_local && local_data[1:0] == 2'b11 && local_data[9:2] == chip_id) begin
      grant_pkt[WIDTH-3 -: 2] = {fifo_full_d, fifo_half_d};
      grant_pkt[WIDTH-1]      = ~^grant_pkt[WIDTH-2:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Routing decision for the latched packet.
  // ---------------------------------------------------------------------------
  logic [NUM_PORTS-1:0] cls_target;
  logic                 cls_local;
  logic                 cls_parity_ok;

  always_comb begin
    cls_target    = '0;
    cls_local     = 1'b0;
    cls_parity_ok = 1'b1;
    if (src_local) begin
      cls_target = enable_piso_upstream;
    end else begin
      cls_parity_ok = ^pkt_reg;
      if (!pkt_reg[1]) begin
        cls_target = enable_piso_upstream;
      end else if (pkt_reg[9:2] == chip_id) begin
        cls_local = 1'b1;
      end else if (pkt_reg[9:2] == GLOBAL_ID) begin
        cls_local  = 1'b1;
        cls_target = enable_piso_downstream;
      end else begin
        cls_target = enable_piso_downstream;
      end
      // Never echo a packet back out of the port it arrived on.
      cls_target = cls_target & ~src_mask;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs.
  // ---------------------------------------------------------------------------
  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n_clk) begin
    if (!reset_n_clk) begin
      // NOTE: the packet and TX data registers are reset too, so a stale packet
      // can never leak out after a reset.
      state          <= IDLE;
      ptr            <= '0;
      pkt_reg        <= '0;
      src_local      <= 1'b0;
      src_mask       <= '0;
      target         <= '0;
      local_pend     <= 1'b0;
      fifo_full_d    <= 1'b0;
      fifo_half_d    <= 1'b0;
      rx_ack         <= '0;
      local_ack      <= 1'b0;
      ld_tx          <= '0;
      tx_data        <= '0;
      to_local_data  <= '0;
      to_local_valid <= 1'b0;
      pkt_forwarded  <= '0;
      pkt_dropped    <= '0;
    end else begin
      fifo_full_d <= fifo_full;
      fifo_half_d <= fifo_half;
      rx_ack      <= '0;
      local_ack   <= 1'b0;
      ld_tx       <= '0;

      case (state)
        IDLE: begin
          if (grant_found) begin
            pkt_reg   <= grant_pkt;
            src_local <= grant_local;
            src_mask  <= grant_src;
            rx_ack    <= grant_src;
            local_ack <= grant_local;
            ptr       <= grant_local ? '0 : grant_idx + SLOT_W'(1);
            state     <= GRANT;
          end
        end

        GRANT: begin
          target     <= cls_target;
          local_pend <= cls_local;
          if (!cls_parity_ok || (cls_target == '0 && !cls_local)) begin
            if (~&pkt_dropped) pkt_dropped <= pkt_dropped + CNT_BITS'(1);
            state <= IDLE;
          end else begin
            state <= CLASSIFY;
          end
        end

        CLASSIFY: begin
          if (target != '0) begin
            state <= WAIT_TX;
          end else begin
            to_local_valid <= 1'b1;
            to_local_data  <= pkt_reg;
            state          <= DELIVER;
          end
        end

        WAIT_TX: begin
          if ((tx_busy & target) == '0) begin
            ld_tx <= target;
            for (int j = 0; j < NUM_PORTS; j++) begin
              if (target[j]) tx_data[j*WIDTH +: WIDTH] <= pkt_reg;
            end
            if (~&pkt_forwarded) pkt_forwarded <= pkt_forwarded + CNT_BITS'(1);
            state <= LOAD;
          end
        end

        // ld_tx is visible this cycle; GUARD then gives tx_busy time to rise.
        LOAD: state <= GUARD;

        GUARD: begin
          if (local_pend) begin
            to_local_valid <= 1'b1;
            to_local_data  <= pkt_reg;
            state          <= DELIVER;
          end else begin
            state <= IDLE;
          end
        end

        DELIVER: begin
          if (to_local_ready) begin
            to_local_valid <= 1'b0;
            state          <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hydra_router.sv
// -----------------------------------------------------------------------------
// tb_hydra_router
//
// Self-checking bench for hydra_router (NUM_PORTS=4, WIDTH=64). CNT_BITS is
// reduced to 4 so that counter saturation is reachable in a short run.
// Expected TX loads and local deliveries are pushed to scoreboard queues when a
// packet is offered; a negedge monitor pops and compares them as the DUT
// produces them. Routing cases come from a vector table; arbitration order,
// latency, back-pressure, reset and saturation are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_hydra_router;

  localparam int W  = 64;
  localparam int NP = 4;
  localparam int CB = 4;
  localparam logic [CB-1:0] CMAX = '1;

  logic              clk = 1'b0;
  logic              reset_n_clk;
  logic [7:0]        chip_id;
  logic [NP-1:0]     enable_posi, enable_piso_upstream, enable_piso_downstream;
  logic [NP*W-1:0]   rx_data;
  logic [NP-1:0]     rx_valid, rx_ack;
  logic [W-1:0]      local_data;
  logic              local_valid, local_ack;
  logic              fifo_full, fifo_half;
  logic [W-1:0]      to_local_data;
  logic              to_local_valid, to_local_ready;
  logic [NP*W-1:0]   tx_data;
  logic [NP-1:0]     ld_tx, tx_busy;
  logic [CB-1:0]     pkt_forwarded, pkt_dropped;

  always #5 clk = ~clk;

  hydra_router #(.WIDTH(W), .NUM_PORTS(NP), .GLOBAL_ID(8'hFF), .CNT_BITS(CB)) dut (
    .clk                    (clk),
    .reset_n_clk            (reset_n_clk),
    .chip_id                (chip_id),
    .enable_posi            (enable_posi),
    .enable_piso_upstream   (enable_piso_upstream),
    .enable_piso_downstream (enable_piso_downstream),
    .rx_data                (rx_data),
    .rx_valid               (rx_valid),
    .rx_ack                 (rx_ack),
    .local_data             (local_data),
    .local_valid            (local_valid),
    .local_ack              (local_ack),
    .fifo_full              (fifo_full),
    .fifo_half              (fifo_half),
    .to_local_data          (to_local_data),
    .to_local_valid         (to_local_valid),
    .to_local_ready         (to_local_ready),
    .tx_data                (tx_data),
    .ld_tx                  (ld_tx),
    .tx_busy                (tx_busy),
    .pkt_forwarded          (pkt_forwarded),
    .pkt_dropped            (pkt_dropped)
  );

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int          cyc   = 0;
  int          last_ld_cyc = -1;
  logic [CB-1:0] exp_fwd = '0;
  logic [CB-1:0] exp_drop = '0;

  typedef struct {
    logic [NP-1:0] mask;
    logic [W-1:0]  data;
  } txe_t;

  txe_t         tx_q[$];
  logic [W-1:0] loc_q[$];

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [CB-1:0] sat_inc(input logic [CB-1:0] v);
    return (v == CMAX) ? v : v + 1'b1;
  endfunction

  // Packet builder: {parity, 0, payload[51:0], id[7:0], type[1:0]}.
  function automatic logic [W-1:0] mk(input logic [1:0] typ, input logic [7:0] id,
                                      input logic [51:0] payload, input bit good);
    logic [W-1:0] p;
    p     = {1'b0, 1'b0, payload, id, typ};
    p[63] = good ? ~(^p[62:0]) : (^p[62:0]);
    return p;
  endfunction

  function automatic logic [W-1:0] with_status(input logic [W-1:0] p, input logic f, input logic h);
    logic [W-1:0] r;
    r        = p;
    r[61:60] = {f, h};
    r[63]    = ~(^r[62:0]);
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Scoreboard monitor, sampled on the falling edge.
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    txe_t         e;
    logic [W-1:0] d;
    if (ld_tx !== '0) begin
      last_ld_cyc = cyc;
      if (tx_q.size() == 0) begin
        check("unexpected_ld_tx", 64'(ld_tx), 64'd0);
      end else begin
        e = tx_q.pop_front();
        check("ld_tx_mask", 64'(ld_tx), 64'(e.mask));
        for (int j = 0; j < NP; j++)
          if (e.mask[j]) check($sformatf("tx_data[%0d]", j), tx_data[j*W +: W], e.data);
      end
    end
    if (to_local_valid === 1'b1 && to_local_ready === 1'b1) begin
      if (loc_q.size() == 0) begin
        check("unexpected_to_local", 64'(to_local_valid), 64'd0);
      end else begin
        d = loc_q.pop_front();
        check("to_local_data", to_local_data, d);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offer one packet on slot src (NP = local FIFO); lat = edges until the ack.
  task automatic send(input int src, input logic [W-1:0] p, output int lat);
    bit got;
    got = 1'b0;
    lat = -1;
    if (src == NP) begin
      local_data  = p;
      local_valid = 1'b1;
    end else begin
      rx_data[src*W +: W] = p;
      rx_valid[src]       = 1'b1;
    end
    for (int k = 1; k <= 20 && !got; k++) begin
      tick(1);
      if (src == NP ? local_ack : rx_ack[src]) begin
        got = 1'b1;
        lat = k;
      end
    end
    if (src == NP) local_valid = 1'b0;
    else           rx_valid[src] = 1'b0;
    check($sformatf("ack_seen_slot%0d", src), 64'(got), 64'd1);
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_fwd"}, 64'(pkt_forwarded), 64'(exp_fwd));
    check({tag, "_drop"}, 64'(pkt_dropped), 64'(exp_drop));
    check({tag, "_txq_empty"}, 64'(tx_q.size()), 64'd0);
    check({tag, "_locq_empty"}, 64'(loc_q.size()), 64'd0);
  endtask

  // Offer two packets at once and check the grant order.
  task automatic pair(input int a, input int b, input logic [W-1:0] pa, input logic [W-1:0] pb,
                      input string tag);
    int order[$];
    rx_data[a*W +: W] = pa;
    rx_data[b*W +: W] = pb;
    rx_valid[a] = 1'b1;
    rx_valid[b] = 1'b1;
    for (int k = 0; k < 40 && rx_valid != '0; k++) begin
      tick(1);
      for (int j = 0; j < NP; j++)
        if (rx_ack[j]) begin
          order.push_back(j);
          rx_valid[j] = 1'b0;
        end
    end
    rx_valid = '0;
    check({tag, "_first"}, 64'(order.size() > 0 ? order[0] : 99), 64'(a));
    check({tag, "_second"}, 64'(order.size() > 1 ? order[1] : 99), 64'(b));
    tick(10);
  endtask

  // ---------------------------------------------------------------------------
  // Routing vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    int            src;      // 0..NP-1 RX port, NP = local FIFO
    logic [W-1:0]  pkt;
    logic [NP-1:0] up;
    logic [NP-1:0] down;
    logic          full;
    logic          half;
    logic [NP-1:0] exp_ld;   // expected TX load mask (0 = none)
    bit            exp_loc;  // expected local delivery
    bit            exp_stat; // expected FIFO-status insertion
    bit            exp_drop;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int src, input logic [1:0] typ, input logic [7:0] id, input bit good,
                     input logic [NP-1:0] up, input logic [NP-1:0] down,
                     input logic f, input logic h, input logic [NP-1:0] exp_ld,
                     input bit loc, input bit stat, input bit drop);
    vec_t v;
    v.src = src;
    v.pkt = mk(typ, id, 52'h0_3C5A_9E11_7700 + 52'(vecs.size() * 52'h1_0101), good);
    v.up = up; v.down = down; v.full = f; v.half = h;
    v.exp_ld = exp_ld; v.exp_loc = loc; v.exp_stat = stat; v.exp_drop = drop;
    vecs.push_back(v);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [W-1:0] d;
    int lat;
    enable_piso_upstream   = v.up;
    enable_piso_downstream = v.down;
    fifo_full              = v.full;
    fifo_half              = v.half;
    tick(2);
    d = v.exp_stat ? with_status(v.pkt, v.full, v.half) : v.pkt;
    if (v.exp_ld != '0) begin
      tx_q.push_back('{mask: v.exp_ld, data: d});
      exp_fwd = sat_inc(exp_fwd);
    end
    if (v.exp_loc)  loc_q.push_back(d);
    if (v.exp_drop) exp_drop = sat_inc(exp_drop);
    send(v.src, v.pkt, lat);
    tick(10);
    check_counters($sformatf("vec%0d", idx));
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int            lat;
    int            t0;
    logic [W-1:0]  p;

    reset_n_clk = 1'b0;
    chip_id = 8'h12;
    enable_posi = '1;
    enable_piso_upstream = '1;
    enable_piso_downstream = '1;
    rx_data = '0;
    rx_valid = '0;
    local_data = '0;
    local_valid = 1'b0;
    fifo_full = 1'b0;
    fifo_half = 1'b0;
    to_local_ready = 1'b1;
    tx_busy = '0;

    // src, type, id, good, up, down, full, half, exp_ld, loc, stat, drop
    add(1,  2'b10, 8'h12, 1, 4'hF,    4'hF,    0, 0, 4'b0000, 1, 0, 0); // config to this chip
    add(3,  2'b11, 8'hFF, 1, 4'h0,    4'b1011, 0, 0, 4'b0011, 1, 0, 0); // broadcast, no echo
    add(NP, 2'b11, 8'h12, 1, 4'b0110, 4'h0,    1, 1, 4'b0110, 0, 1, 0); // local reply + status
    add(2,  2'b00, 8'h55, 0, 4'hF,    4'hF,    0, 0, 4'b0000, 0, 0, 1); // bad parity
    add(0,  2'b00, 8'h12, 1, 4'hF,    4'h0,    0, 0, 4'b1110, 0, 0, 0); // data upstream
    add(2,  2'b10, 8'h34, 1, 4'hF,    4'b0101, 0, 0, 4'b0001, 0, 0, 0); // other chip downstream
    add(0,  2'b01, 8'h00, 1, 4'b0001, 4'hF,    0, 0, 4'b0000, 0, 0, 1); // only echo port -> drop
    add(NP, 2'b11, 8'h12, 0, 4'b0001, 4'h0,    0, 1, 4'b0001, 0, 1, 0); // local not parity-checked
    add(NP, 2'b10, 8'h12, 1, 4'b1000, 4'h0,    1, 1, 4'b1000, 0, 0, 0); // type 10: no status
    add(NP, 2'b01, 8'h77, 1, 4'b0000, 4'hF,    0, 0, 4'b0000, 0, 0, 1); // local, empty mask
    add(1,  2'b11, 8'h12, 0, 4'hF,    4'hF,    0, 0, 4'b0000, 0, 0, 1); // bad parity config
    add(1,  2'b11, 8'hFF, 1, 4'h0,    4'b0010, 0, 0, 4'b0000, 1, 0, 0); // broadcast, mask only src
    add(3,  2'b11, 8'h12, 1, 4'hF,    4'hF,    1, 1, 4'b0000, 1, 0, 0); // RX reply: no status

    // Reset values.
    tick(3);
    reset_n_clk = 1'b1;
    tick(2);
    check("rst_rx_ack", 64'(rx_ack), 64'd0);
    check("rst_local_ack", 64'(local_ack), 64'd0);
    check("rst_ld_tx", 64'(ld_tx), 64'd0);
    check("rst_to_local_valid", 64'(to_local_valid), 64'd0);
    check("rst_to_local_data", to_local_data, 64'd0);
    check("rst_tx_data_any", 64'(|tx_data), 64'd0);
    check_counters("rst");

    // Arbitration: pointer 0 serves 0 then 2; pointer 3 then serves 3 before 1.
    p = mk(2'b00, 8'h01, 52'hA_AAAA_0000_0001, 1);
    tx_q.push_back('{mask: 4'b1110, data: p});
    tx_q.push_back('{mask: 4'b1011, data: mk(2'b00, 8'h02, 52'hA_AAAA_0000_0002, 1)});
    exp_fwd = sat_inc(sat_inc(exp_fwd));
    pair(0, 2, p, mk(2'b00, 8'h02, 52'hA_AAAA_0000_0002, 1), "arb_0_2");
    p = mk(2'b00, 8'h03, 52'hA_AAAA_0000_0003, 1);
    tx_q.push_back('{mask: 4'b0111, data: p});
    tx_q.push_back('{mask: 4'b1101, data: mk(2'b00, 8'h04, 52'hA_AAAA_0000_0004, 1)});
    exp_fwd = sat_inc(sat_inc(exp_fwd));
    pair(3, 1, p, mk(2'b00, 8'h04, 52'hA_AAAA_0000_0004, 1), "arb_3_1");
    check_counters("arb");

    // Routing table.
    foreach (vecs[i]) run_vec(vecs[i], i);

    // Latency from an idle router: ack at +1, ld_tx at +4, ack is one cycle.
    enable_piso_upstream = 4'b0010;
    tick(2);
    p = mk(2'b00, 8'h09, 52'h1_2345_6789_ABCD, 1);
    tx_q.push_back('{mask: 4'b0010, data: p});
    exp_fwd = sat_inc(exp_fwd);
    t0 = cyc;
    send(0, p, lat);
    check("lat_ack", 64'(lat), 64'd1);
    tick(1);
    check("ack_one_cycle", 64'(rx_ack), 64'd0);
    tick(8);
    check("lat_ld_tx", 64'(last_ld_cyc - t0), 64'd4);
    check_counters("lat");

    // Local delivery held while the comms controller is not ready.
    to_local_ready = 1'b0;
    p = mk(2'b10, 8'h12, 52'h5_0505_0505_0505, 1);
    loc_q.push_back(p);
    send(1, p, lat);
    tick(6);
    check("hold_valid", 64'(to_local_valid), 64'd1);
    check("hold_data", to_local_data, p);
    to_local_ready = 1'b1;
    tick(3);
    check("hold_released", 64'(to_local_valid), 64'd0);
    check_counters("hold");

    // Back-pressure: tx_busy[0] held 20 cycles, ld_tx the cycle after it drops.
    enable_piso_upstream = 4'b0001;
    tx_busy = 4'b0001;
    p = mk(2'b00, 8'h21, 52'h7_7777_0000_1111, 1);
    tx_q.push_back('{mask: 4'b0001, data: p});
    exp_fwd = sat_inc(exp_fwd);
    send(2, p, lat);
    tick(19);
    t0 = cyc;
    tx_busy = '0;
    tick(8);
    check("busy_ld_cycle", 64'(last_ld_cyc), 64'(t0 + 1));
    check_counters("busy");

    // Reset while waiting for TX: everything clears, packet is not counted.
    tx_busy = 4'b0001;
    send(1, mk(2'b00, 8'h31, 52'h6_6666_6666_6666, 1), lat);
    tick(3);
    #2;
    reset_n_clk = 1'b0;
    #1;
    check("arst_rx_ack", 64'(rx_ack), 64'd0);
    check("arst_ld_tx", 64'(ld_tx), 64'd0);
    check("arst_to_local_valid", 64'(to_local_valid), 64'd0);
    check("arst_tx_data_any", 64'(|tx_data), 64'd0);
    exp_fwd  = '0;
    exp_drop = '0;
    check("arst_fwd", 64'(pkt_forwarded), 64'(exp_fwd));
    check("arst_drop", 64'(pkt_dropped), 64'(exp_drop));
    tick(2);
    reset_n_clk = 1'b1;
    tx_busy = '0;
    tick(12);
    check_counters("arst");

    // Saturation of both counters.
    for (int i = 0; i < 18; i++) begin
      exp_drop = sat_inc(exp_drop);
      send(0, mk(2'b00, 8'h40, 52'(i), 0), lat);
      tick(3);
    end
    check("drop_saturated", 64'(pkt_dropped), 64'(CMAX));
    enable_piso_upstream = 4'b0010;
    for (int i = 0; i < 17; i++) begin
      p = mk(2'b01, 8'h41, 52'h8_0000_0000_0000 + 52'(i), 1);
      tx_q.push_back('{mask: 4'b0010, data: p});
      exp_fwd = sat_inc(exp_fwd);
      send(0, p, lat);
      tick(6);
    end
    tick(4);
    check("fwd_saturated", 64'(pkt_forwarded), 64'(CMAX));
    check_counters("sat");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: run did not finish, got timeout, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule
